// File: rtl/afifo_pkg.sv
// afifo_pkg: shared types and constants for the async-FIFO read-side streamer.
//   data_ty     - default-width data word
//   rd_state_e  - read-side control states
//   FRAME_CNT_W - width of the completed-frame counter
//   idx_w()     - word-index width for a given frame length (at least 1 bit)
package afifo_pkg;
   localparam int DATA_W      = 8;
   localparam int FRAME_CNT_W = 16;

   typedef logic [DATA_W-1:0] data_ty;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/afifo_rd_skid.sv
// afifo_rd_skid: 2-entry FIFO-ordered skid buffer.
//   clk_read, rd_rst - clock / async active-high reset
//   push, din        - write a word (caller never pushes into a full buffer
//                      unless it also pops in the same cycle)
//   pop              - retire the head word (caller only pops when occ>0)
//   dout             - head word
//   occ              - occupancy 0..2
module afifo_rd_skid
   import afifo_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk_read,
   input  logic             rd_rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       occ
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk_read or posedge rd_rst) begin
      if (rd_rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         // simultaneous push and pop leaves occupancy unchanged
         occ <= occ + 2'(push) - 2'(pop);
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: pulls words out of an async FIFO's read port and presents
// them as a valid/ready stream grouped into frames of FRAME_LEN words.
//   clk_read, rd_rst  - read-domain clock / async active-high reset
//   en                - 1 = keep fetching, 0 = stop fetching and drain
//   fifo_empty        - FIFO empty flag
//   fifo_pop          - FIFO pop strobe (combinational)
//   fifo_data         - FIFO read data, valid the cycle after a pop
//   m_valid, m_ready  - output handshake
//   m_data, m_last    - output word and end-of-frame marker
//   frame_cnt         - completed frames (wraps)
//   busy              - control not in IDLE
module afifo_rd_stream
   import afifo_pkg::*;
#(
   parameter int WIDTH     = DATA_W,
   parameter int FRAME_LEN = 4
) (
   input  logic                   clk_read,
   input  logic                   rd_rst,
   input  logic                   en,
   input  logic                   fifo_empty,
   output logic                   fifo_pop,
   input  logic [WIDTH-1:0]       fifo_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [WIDTH-1:0]       m_data,
   output logic                   m_last,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   busy
);

   localparam int             IDX_W    = idx_w(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   rd_state_e        state;
   logic             infl;   // pop issued last cycle, data arrives now
   logic [1:0]       occ;
   logic [IDX_W-1:0] idx;
   logic             xfer;

   assign m_valid = (occ != 2'd0);
   assign xfer    = m_valid & m_ready;
   assign m_last  = (idx == LAST_IDX);
   assign busy    = (state != IDLE);

   // occ+infl never exceeds 2, so "occ+infl-xfer < 2" is evaluated as
   // "occ+infl < 2+xfer" to keep the arithmetic unsigned.
   assign fifo_pop = (state == RUN) && !fifo_empty &&
                     (({1'b0, occ} + {2'b0, infl}) < (3'd2 + {2'b0, xfer}));

   afifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
      .clk_read (clk_read),
      .rd_rst   (rd_rst),
      .push     (infl),
      .pop      (xfer),
      .din      (fifo_data),
      .dout     (m_data),
      .occ      (occ)
   );

   always_ff @(posedge clk_read or posedge rd_rst) begin
      if (rd_rst) begin
         state     <= IDLE;
         infl      <= 1'b0;
         idx       <= '0;
         frame_cnt <= '0;
      end else begin
         infl <= fifo_pop;

         case (state)
            IDLE:    if (en) state <= RUN;
            RUN:     if (!en) state <= DRAIN;
            DRAIN: begin
               if (en)
                  state <= RUN;
               else if (occ == 2'd0 && !infl)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // idx survives DRAIN/IDLE so a paused frame resumes where it left off
         if (xfer) begin
            if (m_last) begin
               idx       <= '0;
               frame_cnt <= frame_cnt + 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/afifo_rd_stream.md
AFIFO_RD_STREAM -- requirements
Module: afifo_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 4, giving words per frame, legal range 1..256.
REQ-003 SHALL use one clock and an asynchronous active-high reset: clk_read, rd_rst.
REQ-004 clk_read  in  1  read-domain clock; all logic rises on its posedge.
REQ-005 rd_rst  in  1  asynchronous active-high reset.
REQ-006 en  in  1  run enable; 1 = fetch from FIFO, 0 = stop fetching and drain.
REQ-007 fifo_empty  in  1  FIFO empty flag.
REQ-008 fifo_pop  out  1  FIFO pop strobe, one word per cycle high.
REQ-009 fifo_data  in  WIDTH (data_ty)  FIFO read data, valid the cycle after the pop.
REQ-010 m_valid  out  1  output word valid.
REQ-011 m_ready  in  1  downstream accepts the word.
REQ-012 m_data  out  WIDTH (data_ty)  output word.
REQ-013 m_last  out  1  marks the final word of a frame.
REQ-014 frame_cnt  out  16  count of completed frames.
REQ-015 busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL transfer one word when m_valid and m_ready are both high in the same cycle.
- m_data, m_last and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-017 SHALL buffer words in a 2-entry FIFO-ordered skid buffer.
- occ = buffer occupancy, range 0..2.
- infl = pop issued last cycle, 1 bit.
REQ-018 SHALL assert fifo_pop combinationally iff state=RUN and fifo_empty=0 and (occ + infl - xfer) < 2, where xfer = m_valid & m_ready.
REQ-019 SHALL never assert fifo_pop while fifo_empty=1 or in any state other than RUN.
REQ-020 SHALL capture fifo_data into the buffer at the clock edge ending the cycle after a pop.
- m_valid SHALL rise the following cycle.
- Latency from pop cycle t to m_valid = t+2.
REQ-021 SHALL sustain 1 word/cycle when the FIFO is non-empty and m_ready is held at 1.
REQ-022 SHALL never drop or duplicate a word.
- With simultaneous capture and transfer, occ stays unchanged.
REQ-023 SHALL keep a word index idx of 0..FRAME_LEN-1.
- m_last = (idx == FRAME_LEN-1).
- idx increments on each transfer and wraps to 0 after a transfer with m_last=1.
REQ-024 SHALL increment frame_cnt on each transfer with m_last=1, wrapping from 0xFFFF to 0.
REQ-025 SHALL implement the states IDLE, RUN and DRAIN.
- IDLE -> RUN when en=1.
- RUN -> DRAIN when en=0.
- DRAIN -> RUN when en=1.
- DRAIN -> IDLE when occ=0 and infl=0.
REQ-026 SHALL capture, in DRAIN, a word still in flight and present all buffered words normally.
- idx SHALL persist across DRAIN/IDLE; frames are not truncated.
REQ-027 SHALL, when FRAME_LEN=1, assert m_last on every word.

Reset
REQ-028 SHALL on rd_rst asynchronously set state=IDLE, occ=0, infl=0, idx=0 and frame_cnt=0.
- Outputs SHALL reset to fifo_pop=0, m_valid=0, m_last=0 (if FRAME_LEN>1), busy=0 and m_data=0.
REQ-029 SHALL discard buffered and in-flight words when reset asserts mid-operation.
- SHALL NOT assert fifo_pop in the first cycle after release.

Structure
REQ-030 data_ty, state enum rd_state_e {IDLE,RUN,DRAIN} and FRAME_CNT_W=16 SHALL live in afifo_pkg.
REQ-031 The skid buffer SHALL be the sub-module afifo_rd_skid, with ports push, pop, din, dout, occ, on clk_read/rd_rst.

Verification
REQ-032 Reset release, fifo_empty=0, en=1 -> fifo_pop=1 in cycle 1, m_valid=1 in cycle 3 with the first word, and no pop in cycle 0.
REQ-033 20 words queued, m_ready=1, FRAME_LEN=4 -> 20 consecutive transfers in order, m_last on words 4/8/12/16/20, frame_cnt=5.
REQ-034 m_ready=0 for 10 cycles mid-stream -> at most 2 pops beyond the stall, m_data stable, and no loss or duplication after resume.
REQ-035 en dropped the cycle after a pop -> in-flight word delivered, busy stays high until occ=0, then state IDLE and no further pops.
REQ-036 rd_rst pulsed with occ=2 -> m_valid=0 immediately, and on restart the next word is the one after those discarded, with idx=0.
REQ-037 frame_cnt preset near wrap by 65536 frames at FRAME_LEN=1 -> frame_cnt returns to 0 with no glitch on m_last.
